// File: rtl/password_pkg.sv
// password_pkg: shared FSM state type and keypad digit constants for password_checker.
package password_pkg;
    localparam int DIGIT_W    = 4;
    localparam int NUM_DIGITS = 4;
    localparam int MAX_DIGIT  = 9;
    typedef enum logic [1:0] {ENTRY, CHECK, OPEN, LOCKOUT} state_t;
endpackage

// File: rtl/key_edge_detect.sv
// key_edge_detect: registers key_pressed and flags its rising edge.
module key_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic key_pressed,
    output logic key_edge
);
    logic key_q, key_d;
    always_comb key_d = key_pressed;
    always_ff @(posedge clk or posedge rst)
        if (rst) key_q <= 1'b0;
        else     key_q <= key_d;
    assign key_edge = key_pressed & ~key_q;
endmodule

// File: rtl/password_checker.sv
// password_checker: keypad code lock with timed unlock window and lockout
// after MAX_FAILS consecutive wrong entries.
module password_checker import password_pkg::*; #(
    parameter logic [DIGIT_W*NUM_DIGITS-1:0] PASSWORD = 16'h1234,
    parameter int OPEN_CYCLES = 8,
    parameter int LOCK_CYCLES = 16,
    parameter int MAX_FAILS   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key_pressed,
    input  logic [DIGIT_W-1:0] digit,
    input  logic               clear,
    output logic               unlocked,
    output logic               fail,
    output logic               alarm,
    output logic [2:0]         digit_count
);
    localparam int EW = DIGIT_W * NUM_DIGITS;
    localparam int DMAX = OPEN_CYCLES > LOCK_CYCLES ? OPEN_CYCLES : LOCK_CYCLES;
    localparam int DW = $clog2(DMAX + 1);
    localparam int FW = $clog2(MAX_FAILS + 1);
    localparam logic [DW-1:0] OPEN_LAST = DW'(OPEN_CYCLES - 1);
    localparam logic [DW-1:0] LOCK_LAST = DW'(LOCK_CYCLES - 1);
    localparam logic [FW-1:0] FAIL_MAX  = FW'(MAX_FAILS);

    state_t         state_q, state_d;
    logic [EW-1:0]  entry_q, entry_d;
    logic [2:0]     count_q, count_d;
    logic [FW-1:0]  fails_q, fails_d, fails_inc;
    logic [DW-1:0]  dwell_q, dwell_d;
    logic           key_edge, accept, match;

    key_edge_detect u_edge (.clk(clk), .rst(rst), .key_pressed(key_pressed), .key_edge(key_edge));

    assign accept    = key_edge && digit <= DIGIT_W'(MAX_DIGIT);
    assign match     = entry_q == PASSWORD;
    assign fails_inc = fails_q == FAIL_MAX ? fails_q : fails_q + FW'(1);

    always_comb begin
        state_d = state_q;
        entry_d = entry_q;
        count_d = count_q;
        fails_d = fails_q;
        dwell_d = dwell_q;
        case (state_q)
            ENTRY: begin
                if (clear) begin
                    entry_d = '0;
                    count_d = '0;
                end else if (accept) begin
                    entry_d = {entry_q[EW-DIGIT_W-1:0], digit};
                    count_d = count_q + 3'd1;
                    state_d = count_q == 3'(NUM_DIGITS - 1) ? CHECK : ENTRY;
                end
            end
            CHECK: begin
                entry_d = '0;
                count_d = '0;
                dwell_d = '0;
                state_d = match ? OPEN : fails_inc == FAIL_MAX ? LOCKOUT : ENTRY;
                fails_d = match || fails_inc == FAIL_MAX ? '0 : fails_inc;
            end
            OPEN: begin
                state_d = dwell_q == OPEN_LAST ? ENTRY : OPEN;
                dwell_d = dwell_q == OPEN_LAST ? '0 : dwell_q + DW'(1);
            end
            default: begin
                state_d = dwell_q == LOCK_LAST ? ENTRY : LOCKOUT;
                dwell_d = dwell_q == LOCK_LAST ? '0 : dwell_q + DW'(1);
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= ENTRY;
            entry_q <= '0;
            count_q <= '0;
            fails_q <= '0;
            dwell_q <= '0;
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
            count_q <= count_d;
            fails_q <= fails_d;
            dwell_q <= dwell_d;
        end

    // fail is qualified by the registered entry, so it only depends on flops
    assign unlocked    = state_q == OPEN;
    assign alarm       = state_q == LOCKOUT;
    assign fail        = state_q == CHECK && !match;
    assign digit_count = count_q;
endmodule

// File: tb/tb_password_checker.sv
// tb_password_checker: directed stimulus with an event scoreboard of output pulse runs.
module tb_password_checker;
    localparam int EV_FAIL = 1, EV_OPEN = 2, EV_ALARM = 3;

    logic       clk = 1'b0, rst = 1'b1, key_pressed = 1'b0, clear = 1'b0;
    logic [3:0] digit = 4'd0;
    logic       unlocked, fail, alarm;
    logic [2:0] digit_count;
    logic [5:0] status;
    logic [15:0] q[$];
    int errors = 0, checks = 0;
    int fail_run = 0, open_run = 0, alarm_run = 0;

    password_checker dut (
        .clk(clk), .rst(rst), .key_pressed(key_pressed), .digit(digit), .clear(clear),
        .unlocked(unlocked), .fail(fail), .alarm(alarm), .digit_count(digit_count)
    );

    always #5 clk = ~clk;
    assign status = {unlocked, fail, alarm, digit_count};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_ev(input int k, input int l);
        q.push_back({8'(k), 8'(l)});
    endtask

    task automatic report(input int k, input int l);
        logic [15:0] e;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL unexpected_event: got kind %0d len %0d expected none", k, l);
        end else begin
            e = q.pop_front();
            chk("event", {16'd0, 8'(k), 8'(l)}, {16'd0, e});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (fail) fail_run++;
        else if (fail_run > 0) begin report(EV_FAIL, fail_run); fail_run = 0; end
        if (unlocked) open_run++;
        else if (open_run > 0) begin report(EV_OPEN, open_run); open_run = 0; end
        if (alarm) alarm_run++;
        else if (alarm_run > 0) begin report(EV_ALARM, alarm_run); alarm_run = 0; end
    endtask

    task automatic press(input logic [3:0] d, input int hold);
        key_pressed = 1'b1;
        digit = d;
        repeat (hold) tick();
        key_pressed = 1'b0;
        repeat (2) tick();
    endtask

    task automatic enter(input logic [15:0] w);
        for (int i = 3; i >= 0; i--) press(w[i*4 +: 4], 3);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && q.size() > 0; i++) tick();
        chk("wait_idle_pending", q.size(), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("reset_async", status, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        fail_run = 0;
        open_run = 0;
        alarm_run = 0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_state", status, 0);
        tick();
        chk("idle_after_reset", status, 0);

        // correct entry with CHECK-cycle observation
        press(4'd1, 4);
        chk("count_1", digit_count, 1);
        press(4'd2, 3);
        press(4'd3, 5);
        chk("count_3", digit_count, 3);
        expect_ev(EV_OPEN, 8);
        key_pressed = 1'b1;
        digit = 4'd4;
        tick();
        chk("check_state", status, 6'b000_100);
        tick();
        chk("open_state", status, 6'b100_000);
        key_pressed = 1'b0;
        wait_idle(20);
        chk("entry_after_open", status, 0);

        // single wrong entry, then a correct one clears the fail counter
        expect_ev(EV_FAIL, 1);
        enter(16'h1235);
        wait_idle(10);
        chk("after_wrong", status, 0);
        expect_ev(EV_OPEN, 8);
        enter(16'h1234);
        wait_idle(20);

        // three wrong entries -> lockout, keys ignored during it
        repeat (3) expect_ev(EV_FAIL, 1);
        expect_ev(EV_ALARM, 16);
        repeat (3) enter(16'h1235);
        chk("in_lockout", status, 6'b001_000);
        press(4'd1, 1);
        press(4'd2, 1);
        wait_idle(30);
        chk("after_lockout_count", digit_count, 0);
        expect_ev(EV_OPEN, 8);
        enter(16'h1234);
        wait_idle(20);

        // invalid digit, long hold, clear, clear beating a key edge
        press(4'hA, 3);
        chk("invalid_digit", digit_count, 0);
        press(4'd1, 20);
        chk("long_hold", digit_count, 1);
        press(4'd2, 2);
        chk("count_2", digit_count, 2);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clear", digit_count, 0);
        clear = 1'b1;
        key_pressed = 1'b1;
        digit = 4'd3;
        tick();
        clear = 1'b0;
        tick();
        chk("clear_wins", digit_count, 0);
        key_pressed = 1'b0;
        tick();
        expect_ev(EV_OPEN, 8);
        enter(16'h1234);
        wait_idle(20);

        // clear does not forgive earlier failures
        repeat (2) expect_ev(EV_FAIL, 1);
        repeat (2) enter(16'h1235);
        press(4'd1, 2);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        expect_ev(EV_FAIL, 1);
        expect_ev(EV_ALARM, 16);
        enter(16'h1235);
        wait_idle(40);

        // reset during OPEN and during LOCKOUT
        enter(16'h1234);
        chk("open_before_reset", status, 6'b100_000);
        do_reset();
        repeat (3) expect_ev(EV_FAIL, 1);
        repeat (3) enter(16'h1235);
        chk("lockout_before_reset", status, 6'b001_000);
        do_reset();
        wait_idle(5);

        // reset forgets the fail count
        repeat (2) expect_ev(EV_FAIL, 1);
        repeat (2) enter(16'h1235);
        do_reset();
        expect_ev(EV_FAIL, 1);
        enter(16'h1235);
        wait_idle(10);
        repeat (20) tick();
        chk("no_lockout_after_reset", status, 0);

        // key already held when reset releases counts as an edge
        rst = 1'b1;
        key_pressed = 1'b1;
        digit = 4'd5;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("held_key_after_reset", digit_count, 1);
        key_pressed = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
        chk("final_idle", status, 0);
        chk("queue_empty", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/password_checker.md
PASSWORD_CHECKER -- requirements
Module: password_checker

Interface
REQ-001 Parameter PASSWORD, 16'h1234, four BCD digits; the most significant nibble is entered first.
REQ-002 Parameter OPEN_CYCLES, 8, number of cycles unlocked stays high after a correct entry.
REQ-003 Parameter LOCK_CYCLES, 16, number of cycles spent in lockout.
REQ-004 Parameter MAX_FAILS, 3, number of consecutive wrong entries that triggers lockout.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 key_pressed  input  1  level; high while any keypad button is held.
REQ-008 digit  input  4  encoded digit from the keypad encoder; valid while key_pressed is high.
REQ-009 clear  input  1  level; discards the partial entry.
REQ-010 unlocked  output  1  high while in OPEN.
REQ-011 fail  output  1  one-cycle pulse on a wrong 4-digit entry.
REQ-012 alarm  output  1  high while in LOCKOUT.
REQ-013 digit_count  output  3  number of digits accepted so far in the current entry (0-4).

Function
REQ-014 A digit SHALL be accepted only on a rising edge of key_pressed: key_pressed=1 and the registered previous key_pressed=0.
- Holding the key SHALL yield exactly one acceptance.
REQ-015 A digit value greater than 9 SHALL be ignored: no acceptance, and digit_count is unchanged.
REQ-016 Each accepted digit SHALL be shifted into a 16-bit entry register, and digit_count SHALL increment on the following clock edge.
REQ-017 FSM states:
- ENTRY: collecting digits.
- CHECK: one cycle; compares the entry register with PASSWORD.
- OPEN: unlocked is high.
- LOCKOUT: alarm is high.
REQ-018 ENTRY->CHECK SHALL occur on the edge that accepts the 4th digit.
- In CHECK, digit_count reads 4.
- In CHECK, key edges SHALL be ignored.
REQ-019 CHECK with a match -> OPEN.
- The fail counter is cleared.
- The entry register and digit_count are cleared.
REQ-020 CHECK with a mismatch: fail is high for that single CHECK cycle, and the fail counter increments.
- If the new count equals MAX_FAILS -> LOCKOUT, with the fail counter cleared.
- Otherwise -> ENTRY.
- In both cases the entry register and digit_count are cleared.
REQ-021 OPEN SHALL last exactly OPEN_CYCLES cycles, then return to ENTRY.
- Key edges and clear SHALL be ignored in OPEN.
REQ-022 LOCKOUT SHALL last exactly LOCK_CYCLES cycles, then return to ENTRY.
- All inputs except rst SHALL be ignored in LOCKOUT.
REQ-023 clear=1 in ENTRY SHALL zero the entry register and digit_count on the next edge.
- The fail counter is unchanged.
- If a key edge occurs in the same cycle, clear SHALL win and the digit is dropped.
REQ-024 The dwell counter SHALL be sized from max(OPEN_CYCLES, LOCK_CYCLES) and SHALL never wrap.
REQ-025 The fail counter SHALL be sized from MAX_FAILS and SHALL saturate.
REQ-026 Outputs SHALL be decoded from registered state only; there are no combinational input-to-output paths.

Reset
REQ-027 rst SHALL immediately force the following values, regardless of state, including mid-entry, OPEN, or LOCKOUT:
- state=ENTRY
- entry register=0, digit_count=0
- fail counter=0, dwell counter=0
- registered key_pressed=0
- unlocked=0, fail=0, alarm=0
REQ-028 After rst deasserts, a key_pressed that is already high SHALL count as a rising edge on the first clock.

Structure
REQ-029 Package password_pkg SHALL hold:
- the FSM state enum
- DIGIT_W=4, NUM_DIGITS=4, MAX_DIGIT=9
REQ-030 Sub-module key_edge_detect SHALL contain the key_pressed register and the rising-edge logic.
- Everything else is in password_checker.

Verification
REQ-031 Correct entry: press 1,2,3,4, each a multi-cycle hold.
- Required: one fail-free CHECK, then unlocked=1 for exactly 8 cycles, then ENTRY with digit_count=0.
REQ-032 Wrong entry: press 1,2,3,5.
- Required: fail pulse of one cycle, unlocked stays 0, return to ENTRY.
REQ-033 Three wrong entries in a row.
- Required: alarm=1 for exactly 16 cycles; key presses during this window are ignored.
- Then a correct 1,2,3,4 unlocks.
REQ-034 Edge cases:
- digit=4'hA press leaves digit_count unchanged.
- A single press held for 20 cycles yields digit_count=1.
- clear after 2 digits gives digit_count=0, then 1,2,3,4 unlocks.
REQ-035 Reset mid-operation: rst pulse during OPEN and again during LOCKOUT.
- Required: outputs immediately 0 and digit_count=0.
- Two wrong entries followed by a reset, then one more wrong entry, does not trigger lockout.
